dvp_capture: RTL and testbench

Parametrised DVP (8-bit parallel camera) capture front end for the sensor path. It:
- Detects frame start from VSYNC and assembles BYTES_PER_PIX bytes into one pixel.
- Tracks row and column, and applies a runtime crop window.
- Reports per-frame geometry and sticky error flags.
- Feeds the framebuffer writer, which has no back-pressure.

---
 rtl/dvp_pkg.sv | 24 ++
 rtl/dvp_pixel_pack.sv | 62 ++++++
 rtl/dvp_capture.sv | 198 +++++++++++++++++++
 tb/tb_dvp_capture.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// ============================================================================
// Module      : dvp_pkg
// Description : Shared types and helpers for the DVP camera capture front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2
    } state_t;

    localparam int c_DEF_COORD_W = 10;

    function automatic int pix_width(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_pixel_pack.sv
// ============================================================================
// Module      : dvp_pixel_pack
// Description : Packs sensor bytes into pixel slots and flags dropped partials.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_pixel_pack
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int MSB_FIRST     = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_byte_en,
    input  logic                                          i_line_end,
    input  logic [DATA_W-1:0]                             i_data,
    output logic                                          o_pix_done,
    output logic [pix_width(DATA_W, BYTES_PER_PIX)-1:0]   o_pixel,
    output logic                                          o_drop
);

    localparam int c_PIX_W = pix_width(DATA_W, BYTES_PER_PIX);
    localparam int c_IDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(BYTES_PER_PIX - 1);

    logic [c_IDX_W-1:0] r_idx;
    logic [c_PIX_W-1:0] r_acc;
    logic [c_PIX_W-1:0] w_pixel;

    // Byte k of a pixel lands in slot k counted from the top or the bottom.
    for (genvar g = 0; g < BYTES_PER_PIX; g++) begin : g_slot
        localparam int c_SLOT = (MSB_FIRST != 0) ? (BYTES_PER_PIX - 1 - g) : g;
        assign w_pixel[c_SLOT*DATA_W +: DATA_W] =
            (i_byte_en && (r_idx == c_IDX_W'(g))) ? i_data : r_acc[c_SLOT*DATA_W +: DATA_W];
    end

    assign o_pix_done = i_byte_en && (r_idx == c_LAST);
    assign o_pixel    = w_pixel;
    assign o_drop     = i_line_end && (r_idx != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx <= '0;
            r_acc <= '0;
        end else begin
            if (i_byte_en) begin
                r_acc <= w_pixel;
            end
            if (i_line_end || o_pix_done) begin
                r_idx <= '0;
            end else if (i_byte_en) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dvp_capture.sv
// ============================================================================
// Module      : dvp_capture
// Description : DVP capture front end: framing FSM, crop, geometry and errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_capture
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int COORD_W       = c_DEF_COORD_W,
    parameter int VSYNC_POL     = 1,
    parameter int MSB_FIRST     = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_enable,
    input  logic                                          i_vsync,
    input  logic                                          i_href,
    input  logic [DATA_W-1:0]                             i_data,
    input  logic [COORD_W-1:0]                            i_crop_x0,
    input  logic [COORD_W-1:0]                            i_crop_x1,
    input  logic [COORD_W-1:0]                            i_crop_y0,
    input  logic [COORD_W-1:0]                            i_crop_y1,
    input  logic                                          i_clr_err,
    output logic                                          o_valid,
    output logic [pix_width(DATA_W, BYTES_PER_PIX)-1:0]   o_data,
    output logic [COORD_W-1:0]                            o_col,
    output logic [COORD_W-1:0]                            o_row,
    output logic                                          o_sof,
    output logic                                          o_line_done,
    output logic                                          o_frame_done,
    output logic [COORD_W-1:0]                            o_frame_cols,
    output logic [COORD_W-1:0]                            o_frame_rows,
    output logic                                          o_err_line,
    output logic                                          o_err_partial
);

    localparam int c_PIX_W = pix_width(DATA_W, BYTES_PER_PIX);
    localparam logic [COORD_W-1:0] c_CMAX = '1;

    state_t               r_state, w_state_nxt;
    logic                 r_win_q;
    logic                 w_win, w_sof_edge, w_start, w_cap;
    logic                 w_byte_en, w_line_end, w_line_nonempty, w_frame_end;
    logic                 w_pix_done, w_drop, w_in_crop, w_set_line;
    logic [c_PIX_W-1:0]   w_pixel;
    logic [COORD_W-1:0]   r_pix_col, r_row, r_first_len, w_row_inc, w_col_inc;
    logic [COORD_W-1:0]   r_x0, r_x1, r_y0, r_y1;
    logic                 r_first_done, r_sof_pend;

    logic                 r_valid, r_sof, r_line_done, r_frame_done;
    logic                 r_err_line, r_err_partial;
    logic [c_PIX_W-1:0]   r_data;
    logic [COORD_W-1:0]   r_col, r_row_o, r_frame_cols, r_frame_rows;

    assign w_win      = (i_vsync == (VSYNC_POL != 0));
    assign w_sof_edge = w_win & ~r_win_q;
    assign w_cap      = (r_state == ST_CAPTURE);
    assign w_start    = (r_state == ST_WAIT_SOF) & i_enable & w_sof_edge;
    assign w_byte_en  = w_cap & w_win & i_href;
    // Any non-href cycle in capture (including window close) ends the line;
    // repeated idle cycles are harmless because the counters are already 0.
    assign w_line_end      = w_cap & ~(w_win & i_href);
    assign w_line_nonempty = w_line_end & (r_pix_col != '0);
    assign w_frame_end     = w_cap & ~w_win;
    assign w_set_line      = w_line_nonempty & r_first_done & (r_pix_col != r_first_len);

    assign w_row_inc = (r_row == c_CMAX)     ? r_row     : r_row + COORD_W'(1);
    assign w_col_inc = (r_pix_col == c_CMAX) ? r_pix_col : r_pix_col + COORD_W'(1);
    assign w_in_crop = (r_pix_col >= r_x0) && (r_pix_col <= r_x1) &&
                       (r_row >= r_y0) && (r_row <= r_y1);

    dvp_pixel_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .MSB_FIRST     (MSB_FIRST)
    ) u_pack (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_byte_en  (w_byte_en),
        .i_line_end (w_line_end),
        .i_data     (i_data),
        .o_pix_done (w_pix_done),
        .o_pixel    (w_pixel),
        .o_drop     (w_drop)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_nxt = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!i_enable)      w_state_nxt = ST_IDLE;
                else if (w_sof_edge) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!w_win) w_state_nxt = i_enable ? ST_WAIT_SOF : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_win_q       <= 1'b0;
            r_pix_col     <= '0;
            r_row         <= '0;
            r_first_len   <= '0;
            r_first_done  <= 1'b0;
            r_sof_pend    <= 1'b0;
            r_x0          <= '0;
            r_x1          <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_valid       <= 1'b0;
            r_sof         <= 1'b0;
            r_data        <= '0;
            r_col         <= '0;
            r_row_o       <= '0;
            r_line_done   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cols  <= '0;
            r_frame_rows  <= '0;
            r_err_line    <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_q      <= w_win;
            r_valid      <= w_pix_done & w_in_crop;
            r_sof        <= w_pix_done & w_in_crop & r_sof_pend;
            r_line_done  <= w_line_nonempty;
            r_frame_done <= w_frame_end;

            if (w_pix_done) begin
                r_data  <= w_pixel;
                r_col   <= r_pix_col;
                r_row_o <= r_row;
            end
            if (w_pix_done && w_in_crop) begin
                r_sof_pend <= 1'b0;
            end

            if (w_start) begin
                r_x0         <= i_crop_x0;
                r_x1         <= i_crop_x1;
                r_y0         <= i_crop_y0;
                r_y1         <= i_crop_y1;
                r_pix_col    <= '0;
                r_row        <= '0;
                r_first_done <= 1'b0;
                r_first_len  <= '0;
                r_sof_pend   <= 1'b1;
            end else if (w_line_end) begin
                r_pix_col <= '0;
                if (w_line_nonempty) begin
                    r_row <= w_row_inc;
                    if (!r_first_done) begin
                        r_first_done <= 1'b1;
                        r_first_len  <= r_pix_col;
                    end
                end
            end else if (w_pix_done) begin
                r_pix_col <= w_col_inc;
            end

            // The line closing in the same cycle as the window still counts.
            if (w_frame_end) begin
                r_frame_rows <= w_line_nonempty ? w_row_inc : r_row;
                r_frame_cols <= r_first_done ? r_first_len :
                                (w_line_nonempty ? r_pix_col : '0);
            end

            r_err_line    <= w_set_line | (r_err_line & ~i_clr_err);
            r_err_partial <= w_drop | (r_err_partial & ~i_clr_err);
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_col         = r_col;
    assign o_row         = r_row_o;
    assign o_sof         = r_sof;
    assign o_line_done   = r_line_done;
    assign o_frame_done  = r_frame_done;
    assign o_frame_cols  = r_frame_cols;
    assign o_frame_rows  = r_frame_rows;
    assign o_err_line    = r_err_line;
    assign o_err_partial = r_err_partial;

endmodule

`default_nettype wire

// File: tb/tb_dvp_capture.sv
// ============================================================================
// Module      : tb_dvp_capture
// Description : Randomized frame bench; two DUT configurations share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dvp_capture;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, act, href, clr_err;
    logic [7:0] data;
    logic [9:0] x0, x1, y0, y1;
    logic       vs0, vs1;
    assign vs0 = act;
    assign vs1 = ~act;

    logic        v0, sof0, ld0, fd0, el0, ep0;
    logic [15:0] d0;
    logic [9:0]  c0, r0, fc0, fr0;
    logic        v1, sof1, ld1, fd1, el1, ep1;
    logic [7:0]  d1;
    logic [9:0]  c1, r1, fc1, fr1;

    dvp_capture u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_vsync(vs0), .i_href(href),
        .i_data(data), .i_crop_x0(x0), .i_crop_x1(x1), .i_crop_y0(y0), .i_crop_y1(y1),
        .i_clr_err(clr_err), .o_valid(v0), .o_data(d0), .o_col(c0), .o_row(r0),
        .o_sof(sof0), .o_line_done(ld0), .o_frame_done(fd0), .o_frame_cols(fc0),
        .o_frame_rows(fr0), .o_err_line(el0), .o_err_partial(ep0)
    );

    dvp_capture #(.BYTES_PER_PIX(1), .MSB_FIRST(0), .VSYNC_POL(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_vsync(vs1), .i_href(href),
        .i_data(data), .i_crop_x0(x0), .i_crop_x1(x1), .i_crop_y0(y0), .i_crop_y1(y1),
        .i_clr_err(clr_err), .o_valid(v1), .o_data(d1), .o_col(c1), .o_row(r1),
        .o_sof(sof1), .o_line_done(ld1), .o_frame_done(fd1), .o_frame_cols(fc1),
        .o_frame_rows(fr1), .o_err_line(el1), .o_err_partial(ep1)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
        int          r;
        bit          s;
    } pix_t;

    pix_t got0[$], got1[$], exp0[$], exp1[$];
    pix_t mp0, mp1;
    int   n_ld[2], n_fd[2];
    int   e_ld[2], e_fd[2], e_cols[2], e_rows[2];
    bit   e_el[2], e_ep[2];

    int         f_nl;
    int         f_len[8];
    logic [7:0] f_b[8][48];
    bit         f_close;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v0) begin
            mp0.d = 32'(d0); mp0.c = int'(c0); mp0.r = int'(r0); mp0.s = sof0;
            got0.push_back(mp0);
        end
        if (v1) begin
            mp1.d = 32'(d1); mp1.c = int'(c1); mp1.r = int'(r1); mp1.s = sof1;
            got1.push_back(mp1);
        end
        if (ld0) n_ld[0]++;
        if (ld1) n_ld[1]++;
        if (fd0) n_fd[0]++;
        if (fd1) n_fd[1]++;
    end

    // Expected pixels from the frame description: bytes grouped into pixels,
    // leftovers dropped, crop applied, lengths compared against the first line.
    task automatic model(input int sel, input int bpp, input bit msb);
        int          row, first, npix;
        bit          sof;
        pix_t        p;
        logic [31:0] d;
        row = 0; first = -1; sof = 1'b1;
        e_ld[sel] = 0;
        e_fd[sel] = 1;
        for (int l = 0; l < f_nl; l++) begin
            npix = f_len[l] / bpp;
            if (f_len[l] % bpp != 0) e_ep[sel] = 1'b1;
            for (int c = 0; c < npix; c++) begin
                d = '0;
                for (int k = 0; k < bpp; k++) begin
                    if (msb) d = (d << 8) | 32'(f_b[l][c*bpp+k]);
                    else     d = d | (32'(f_b[l][c*bpp+k]) << (8*k));
                end
                if (c >= int'(x0) && c <= int'(x1) && row >= int'(y0) && row <= int'(y1)) begin
                    p.d = d; p.c = c; p.r = row; p.s = sof;
                    sof = 1'b0;
                    if (sel == 0) exp0.push_back(p);
                    else          exp1.push_back(p);
                end
            end
            if (npix > 0) begin
                e_ld[sel]++;
                if (first < 0)          first = npix;
                else if (npix != first) e_el[sel] = 1'b1;
                row++;
            end
        end
        e_rows[sel] = row;
        e_cols[sel] = (first < 0) ? 0 : first;
    endtask

    task automatic drive_frame(input bit rise);
        if (rise) begin
            act = 1'b0;
            repeat (3) @(negedge clk);
            act = 1'b1;
        end
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
        for (int l = 0; l < f_nl; l++) begin
            for (int i = 0; i < f_len[l]; i++) begin
                href = 1'b1;
                data = f_b[l][i];
                @(negedge clk);
            end
            if (f_close && l == f_nl - 1) begin
                act  = 1'b0;
                data = 8'h5A;
                @(negedge clk);
            end
            href = 1'b0;
            data = 8'($urandom);
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end
        act = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_frame(input int sel, input string nm);
        int ng, ne;
        ng = (sel == 0) ? got0.size() : got1.size();
        ne = (sel == 0) ? exp0.size() : exp1.size();
        check_eq({nm, ".npix"}, 64'(ng), 64'(ne));
        for (int i = 0; i < ng && i < ne; i++) begin
            pix_t g, e;
            if (sel == 0) begin g = got0[i]; e = exp0[i]; end
            else          begin g = got1[i]; e = exp1[i]; end
            check_eq({nm, ".data"}, 64'(g.d), 64'(e.d));
            check_eq({nm, ".col"},  64'(g.c), 64'(e.c));
            check_eq({nm, ".row"},  64'(g.r), 64'(e.r));
            check_eq({nm, ".sof"},  64'(g.s), 64'(e.s));
        end
        check_eq({nm, ".line_done"},  64'(n_ld[sel]), 64'(e_ld[sel]));
        check_eq({nm, ".frame_done"}, 64'(n_fd[sel]), 64'(e_fd[sel]));
        check_eq({nm, ".frame_cols"}, 64'((sel == 0) ? fc0 : fc1), 64'(e_cols[sel]));
        check_eq({nm, ".frame_rows"}, 64'((sel == 0) ? fr0 : fr1), 64'(e_rows[sel]));
        check_eq({nm, ".err_line"},   64'((sel == 0) ? el0 : el1), 64'(e_el[sel]));
        check_eq({nm, ".err_partial"},64'((sel == 0) ? ep0 : ep1), 64'(e_ep[sel]));
    endtask

    task automatic clear_obs();
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        for (int s = 0; s < 2; s++) begin
            n_ld[s] = 0; n_fd[s] = 0; e_ld[s] = 0; e_fd[s] = 0;
        end
    endtask

    task automatic run_frame(input string nm, input bit rise, input bit cap);
        clear_obs();
        if (cap) begin
            model(0, 2, 1'b1);
            model(1, 1, 1'b0);
        end
        drive_frame(rise);
        compare_frame(0, nm);
        compare_frame(1, {nm, "/b1"});
    endtask

    task automatic fill(input int nl, input int pix, input bit rnd);
        int n;
        n = 0;
        f_nl = nl;
        f_close = 1'b0;
        for (int l = 0; l < nl; l++) begin
            f_len[l] = 2 * pix;
            for (int i = 0; i < 48; i++) begin
                f_b[l][i] = rnd ? 8'($urandom) : 8'(8'hA0 + 8'h11 * n);
                if (i < f_len[l]) n++;
            end
        end
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        e_el[0] = 1'b0; e_el[1] = 1'b0; e_ep[0] = 1'b0; e_ep[1] = 1'b0;
        check_eq("clr.err_line",    64'({el0, el1}), 64'd0);
        check_eq("clr.err_partial", 64'({ep0, ep1}), 64'd0);
    endtask

    task automatic full_crop();
        x0 = 10'd0; x1 = 10'd1023; y0 = 10'd0; y1 = 10'd1023;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; act = 1'b0; href = 1'b0; clr_err = 1'b0; data = 8'h00;
        full_crop();
        for (int s = 0; s < 2; s++) begin
            e_el[s] = 1'b0; e_ep[s] = 1'b0; e_cols[s] = 0; e_rows[s] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst.valid", 64'({v0, v1, sof0, sof1}), 64'd0);
        check_eq("rst.data",  64'({d0, d1}), 64'd0);
        check_eq("rst.geom",  64'({fc0, fr0, fc1, fr1}), 64'd0);
        check_eq("rst.flags", 64'({ld0, fd0, el0, ep0, ld1, fd1, el1, ep1}), 64'd0);

        enable = 1'b1;
        @(negedge clk);
        fill(4, 3, 1'b0);
        run_frame("basic", 1'b1, 1'b1);

        // Enable raised while a frame is already open: nothing captured.
        enable = 1'b0;
        repeat (2) @(negedge clk);
        act = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        fill(3, 2, 1'b1);
        run_frame("midframe", 1'b0, 1'b0);
        fill(3, 3, 1'b1);
        run_frame("after_mid", 1'b1, 1'b1);

        x0 = 10'd1; x1 = 10'd1; y0 = 10'd2; y1 = 10'd3;
        fill(4, 3, 1'b1);
        run_frame("crop", 1'b1, 1'b1);
        full_crop();

        fill(3, 3, 1'b1);
        f_len[1] = 7;
        run_frame("partial", 1'b1, 1'b1);
        fill(2, 2, 1'b1);
        run_frame("sticky", 1'b1, 1'b1);
        clear_err();

        fill(3, 3, 1'b1);
        f_len[2] = 4;
        run_frame("short", 1'b1, 1'b1);

        fill(2, 3, 1'b1);
        f_close = 1'b1;
        run_frame("close", 1'b1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            clear_err();
            f_nl = $urandom_range(1, 5);
            f_close = ($urandom_range(0, 2) == 0);
            for (int l = 0; l < f_nl; l++) begin
                f_len[l] = 2 * $urandom_range(1, 6) + (($urandom_range(0, 5) == 0) ? 1 : 0);
                for (int i = 0; i < 48; i++) f_b[l][i] = 8'($urandom);
            end
            x0 = 10'($urandom_range(0, 3)); x1 = 10'($urandom_range(2, 8));
            y0 = 10'($urandom_range(0, 2)); y1 = 10'($urandom_range(1, 5));
            run_frame("random", 1'b1, 1'b1);
        end
        full_crop();

        // Leave errors and geometry non-zero, then reset in the middle of a line.
        fill(2, 3, 1'b1);
        f_len[0] = 5;
        run_frame("pre_rst", 1'b1, 1'b1);
        act = 1'b0;
        repeat (2) @(negedge clk);
        act = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            href = 1'b1; data = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst.valid", 64'({v0, v1, sof0, sof1}), 64'd0);
        check_eq("midrst.data",  64'({d0, d1, c0, r0, c1, r1}), 64'd0);
        check_eq("midrst.geom",  64'({fc0, fr0, fc1, fr1}), 64'd0);
        check_eq("midrst.flags", 64'({ld0, fd0, el0, ep0, ld1, fd1, el1, ep1}), 64'd0);
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        href = 1'b0;
        fill(2, 3, 1'b1);
        drive_frame(1'b0);
        check_eq("midrst.no_pix",   64'(got0.size() + got1.size()), 64'd0);
        check_eq("midrst.no_frame", 64'(n_fd[0] + n_fd[1]), 64'd0);
        for (int s = 0; s < 2; s++) begin
            e_el[s] = 1'b0; e_ep[s] = 1'b0; e_cols[s] = 0; e_rows[s] = 0;
        end
        fill(3, 2, 1'b1);
        run_frame("post_rst", 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
